switch_port_arbiter: RTL and testbench

Round-robin output-port arbiter for the `dut_top` packet switch datapath. It shares one switch output port between NUM_REQ input ports. A grant is held for a whole packet, from first beat to end-of-packet. A stall watchdog reclaims the port if the granted source or the downstream sink stops moving. The block drives the output mux select and sits between the input-port FIFOs and the output-port driver in `dut_top`.

---
 rtl/switch_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_switch_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_port_arbiter.sv
// -----------------------------------------------------------------------------
// switch_port_arbiter
//
// Round-robin arbiter that shares one switch output port between NUM_REQ input
// ports. A grant is held for a whole packet (first beat through eop). A stall
// watchdog reclaims the port when neither the granted source nor the
// downstream sink has moved for MAX_STALL consecutive cycles.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   req          per-port "has a packet for this output"
//   valid        per-port "beat presented this cycle"
//   eop          per-port "this beat is the last of the packet" (with valid)
//   out_ready    downstream accepts a beat this cycle
//   grant        one-hot grant, or all zero
//   grant_id     binary index of the granted port (output mux select)
//   sel_valid    a grant is active
//   timeout_err  one-cycle pulse when the watchdog releases a grant
//   pkt_count    packets completed with eop, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module switch_port_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_STALL = 16,
  parameter  int CNT_W     = 16,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] valid,
  input  logic [NUM_REQ-1:0] eop,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_id,
  output logic               sel_valid,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   pkt_count
);

  localparam int SW = $clog2(MAX_STALL + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      grant_id_q, grant_id_d;
  logic               sel_valid_q, sel_valid_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [SW-1:0]      stall_q, stall_d;

  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic               xfer;
  logic [IW-1:0]      next_ptr;

  // Round-robin pick: scan offsets from the far end down to 0 so that the
  // request closest to ptr (smallest offset) is the last one written and wins.
  always_comb begin : picker
    logic [IW-1:0] cand;
    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = IW'((int'(ptr_q) + off) % NUM_REQ);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Only the granted port's valid/eop matter; other ports are ignored.
  assign xfer     = valid[grant_id_q] & out_ready;
  assign next_ptr = (grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + IW'(1);

  always_comb begin : next_state
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    sel_valid_d = sel_valid_q;
    timeout_d   = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    ptr_d       = ptr_q;
    stall_d     = stall_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d     = NUM_REQ'(1) << pick_idx;
          grant_id_d  = pick_idx;
          sel_valid_d = 1'b1;
          stall_d     = '0;
          state_d     = S_GRANT;
        end
      end

      S_GRANT: begin
        if (xfer) begin
          stall_d = '0;
          if (eop[grant_id_q]) begin
            grant_d     = '0;
            sel_valid_d = 1'b0;
            ptr_d       = next_ptr;
            pkt_cnt_d   = pkt_cnt_q + CNT_W'(1);
            state_d     = S_IDLE;
          end
        end else if (stall_q == SW'(MAX_STALL - 1)) begin
          // This idle cycle is the MAX_STALL-th in a row: release the port as
          // an eop would, but flag it instead of counting a packet.
          grant_d     = '0;
          sel_valid_d = 1'b0;
          ptr_d       = next_ptr;
          stall_d     = '0;
          timeout_d   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      grant_id_q  <= '0;
      sel_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      pkt_cnt_q   <= '0;
      ptr_q       <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      sel_valid_q <= sel_valid_d;
      timeout_q   <= timeout_d;
      pkt_cnt_q   <= pkt_cnt_d;
      ptr_q       <= ptr_d;
      stall_q     <= stall_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign sel_valid   = sel_valid_q;
  assign timeout_err = timeout_q;
  assign pkt_count   = pkt_cnt_q;

endmodule

// File: tb/tb_switch_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_switch_port_arbiter
//
// Directed bench for switch_port_arbiter (NUM_REQ=4, MAX_STALL=16, CNT_W=4).
// A table of single-cycle vectors covers reset, packet flow and round-robin
// order; hand-written sequences cover the watchdog, stall restart, reset in
// mid-packet and pkt_count wrap. Inputs change #1 after a rising edge and the
// outputs are compared at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_switch_port_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_STALL = 16;
  localparam int CNT_W     = 4;
  localparam int IW        = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_REQ-1:0] req, valid, eop;
  logic               out_ready;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_id;
  logic               sel_valid;
  logic               timeout_err;
  logic [CNT_W-1:0]   pkt_count;

  int n_checks = 0;
  int n_fail   = 0;

  switch_port_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MAX_STALL(MAX_STALL),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .valid      (valid),
    .eop        (eop),
    .out_ready  (out_ready),
    .grant      (grant),
    .grant_id   (grant_id),
    .sel_valid  (sel_valid),
    .timeout_err(timeout_err),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic               rst;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] eop;
    logic               ord;
    logic [NUM_REQ-1:0] e_grant;
    logic [IW-1:0]      e_id;
    logic               e_sel;
    logic               e_to;
    logic [CNT_W-1:0]   e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst, logic [3:0] r, logic [3:0] v,
                              logic [3:0] e, logic ord, logic [3:0] eg, logic [1:0] eid,
                              logic esel, logic eto, logic [3:0] ecnt);
    vec_t t;
    t.name = name; t.rst = rst; t.req = r; t.valid = v; t.eop = e; t.ord = ord;
    t.e_grant = eg; t.e_id = eid; t.e_sel = esel; t.e_to = eto; t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic [3:0] r, logic [3:0] v, logic [3:0] e, logic ord);
    reset = rst; req = r; valid = v; eop = e; out_ready = ord;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(string name, logic [3:0] eg, logic esel, logic eto,
                            logic [3:0] ecnt);
    check({name, ".grant"}, 32'(grant), 32'(eg));
    check({name, ".sel_valid"}, 32'(sel_valid), 32'(esel));
    check({name, ".timeout_err"}, 32'(timeout_err), 32'(eto));
    check({name, ".pkt_count"}, 32'(pkt_count), 32'(ecnt));
  endtask

  initial begin
    int model_cnt;

    drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // ---------------- table: reset, 3-beat packet, round robin, req drop ----
    vecs.push_back(mk("rst0",     1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("rst1",     1, 4'b0001, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("t1_grant", 0, 4'b0001, 4'b0000, 4'b0000, 1, 4'b0001, 0, 1, 0, 0));
    vecs.push_back(mk("t1_beat1", 0, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 0, 1, 0, 0));
    vecs.push_back(mk("t1_beat2", 0, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 0, 1, 0, 0));
    vecs.push_back(mk("t1_eop",   0, 4'b0001, 4'b0001, 4'b0001, 1, 4'b0000, 0, 0, 0, 1));
    vecs.push_back(mk("t1_ptr1",  0, 4'b1111, 4'b0000, 4'b0000, 1, 4'b0010, 1, 1, 0, 1));
    vecs.push_back(mk("t2_rst",   1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("t2_g0",    0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0001, 0, 1, 0, 0));
    vecs.push_back(mk("t2_r0",    0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 1));
    vecs.push_back(mk("t2_g1",    0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 0, 1));
    vecs.push_back(mk("t2_r1",    0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 2));
    vecs.push_back(mk("t2_g2",    0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0100, 2, 1, 0, 2));
    vecs.push_back(mk("t2_r2",    0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 3));
    vecs.push_back(mk("t2_g3",    0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b1000, 3, 1, 0, 3));
    vecs.push_back(mk("t2_r3",    0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 4));
    vecs.push_back(mk("t2_g0b",   0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0001, 0, 1, 0, 4));
    vecs.push_back(mk("t2_r0b",   0, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 5));
    vecs.push_back(mk("t3_rst",   1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk("t3_g0",    0, 4'b0101, 4'b0000, 4'b0000, 1, 4'b0001, 0, 1, 0, 0));
    vecs.push_back(mk("t3_drop",  0, 4'b0100, 4'b0001, 4'b0000, 1, 4'b0001, 0, 1, 0, 0));
    vecs.push_back(mk("t3_stall", 0, 4'b0100, 4'b0000, 4'b0000, 1, 4'b0001, 0, 1, 0, 0));
    vecs.push_back(mk("t3_eop",   0, 4'b0100, 4'b0001, 4'b0001, 1, 4'b0000, 0, 0, 0, 1));
    vecs.push_back(mk("t3_g2",    0, 4'b0101, 4'b0000, 4'b0000, 1, 4'b0100, 2, 1, 0, 1));
    vecs.push_back(mk("t3_r2",    0, 4'b0101, 4'b0100, 4'b0100, 1, 4'b0000, 0, 0, 0, 2));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].valid, vecs[i].eop, vecs[i].ord);
      tick();
      expect_out(vecs[i].name, vecs[i].e_grant, vecs[i].e_sel, vecs[i].e_to, vecs[i].e_cnt);
      if (vecs[i].e_sel)
        check({vecs[i].name, ".grant_id"}, 32'(grant_id), 32'(vecs[i].e_id));
    end

    // ---------------- watchdog: port 1 stalls MAX_STALL cycles --------------
    drive(1, 4'b0000, 4'b0000, 4'b0000, 0);
    tick();
    drive(0, 4'b0010, 4'b0000, 4'b0000, 1);
    tick();
    expect_out("t4_grant", 4'b0010, 1, 0, 0);
    check("t4_grant.grant_id", 32'(grant_id), 32'd1);
    drive(0, 4'b0010, 4'b0010, 4'b0000, 0);
    for (int k = 1; k < MAX_STALL; k++) begin
      tick();
      expect_out($sformatf("t4_stall%0d", k), 4'b0010, 1, 0, 0);
    end
    tick();
    expect_out("t4_timeout", 4'b0000, 0, 1, 0);
    tick();
    expect_out("t4_regrant", 4'b0010, 1, 0, 0);
    drive(0, 4'b0010, 4'b0010, 4'b0010, 1);
    tick();
    expect_out("t4_eop", 4'b0000, 0, 0, 1);

    // ---------------- stall restart: port 3, 10 stall, beat, 15 stall, eop --
    drive(1, 4'b0000, 4'b0000, 4'b0000, 0);
    tick();
    drive(0, 4'b1000, 4'b0000, 4'b0000, 0);
    tick();
    expect_out("t5_grant", 4'b1000, 1, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      expect_out($sformatf("t5_stallA%0d", k), 4'b1000, 1, 0, 0);
    end
    drive(0, 4'b1000, 4'b1000, 4'b0000, 1);
    tick();
    expect_out("t5_beat", 4'b1000, 1, 0, 0);
    drive(0, 4'b1000, 4'b1000, 4'b0000, 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      expect_out($sformatf("t5_stallB%0d", k), 4'b1000, 1, 0, 0);
    end
    drive(0, 4'b1000, 4'b1000, 4'b1000, 1);
    tick();
    expect_out("t5_eop", 4'b0000, 0, 0, 1);
    drive(0, 4'b1001, 4'b0000, 4'b0000, 1);
    tick();
    expect_out("t5_ptr0", 4'b0001, 1, 0, 1);

    // ---------------- reset in mid-packet from port 2 -----------------------
    drive(1, 4'b0000, 4'b0000, 4'b0000, 0);
    tick();
    drive(0, 4'b0100, 4'b0000, 4'b0000, 1);
    tick();
    expect_out("t6_grant", 4'b0100, 1, 0, 0);
    drive(0, 4'b0100, 4'b0100, 4'b0000, 1);
    tick();
    tick();
    expect_out("t6_mid", 4'b0100, 1, 0, 0);
    drive(1, 4'b0100, 4'b0100, 4'b0000, 1);
    tick();
    expect_out("t6_reset", 4'b0000, 0, 0, 0);
    check("t6_reset.grant_id", 32'(grant_id), 32'd0);
    drive(0, 4'b0100, 4'b0000, 4'b0000, 1);
    tick();
    expect_out("t6_regrant", 4'b0100, 1, 0, 0);
    check("t6_regrant.grant_id", 32'(grant_id), 32'd2);

    // ---------------- pkt_count wraps modulo 2^CNT_W ------------------------
    drive(1, 4'b0000, 4'b0000, 4'b0000, 0);
    tick();
    model_cnt = 0;
    drive(0, 4'b0001, 4'b0001, 4'b0001, 1);
    for (int p = 0; p < (1 << CNT_W) + 1; p++) begin
      tick();
      tick();
      model_cnt = (model_cnt + 1) % (1 << CNT_W);
      check($sformatf("t7_cnt%0d", p), 32'(pkt_count), 32'(model_cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
